// File: rtl/icache_burst_if.sv
// CPU fetch port and DMA refill port of the burst instruction cache,
// bundled so the cache and its environment share one connection.
interface icache_burst_if #(
    parameter int DW = 128,
    parameter int AW = 33
);
    logic [AW-1:0] cpu_addr_i;
    logic          cpu_read_valid_i;
    logic [DW-1:0] ic_data_o;
    logic [AW-1:0] ic_addr_o;
    logic          cpu_read_ack_o;
    logic          flush_i;
    logic [AW-1:0] ic_read_dma_addr_o;
    logic [7:0]    ic_read_dma_len_o;
    logic          ic_read_dma_valid_o;
    logic          ic_read_dma_ready_i;
    logic          ic_read_dma_ack_i;
    logic [DW-1:0] ic_read_dma_data_i;
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;

    // Cache side
    modport slave (
        input  cpu_addr_i, cpu_read_valid_i, flush_i,
        input  ic_read_dma_ready_i, ic_read_dma_ack_i, ic_read_dma_data_i,
        output ic_data_o, ic_addr_o, cpu_read_ack_o,
        output ic_read_dma_addr_o, ic_read_dma_len_o, ic_read_dma_valid_o,
        output hit_cnt_o, miss_cnt_o
    );

    // CPU + DMA engine side
    modport master (
        output cpu_addr_i, cpu_read_valid_i, flush_i,
        output ic_read_dma_ready_i, ic_read_dma_ack_i, ic_read_dma_data_i,
        input  ic_data_o, ic_addr_o, cpu_read_ack_o,
        input  ic_read_dma_addr_o, ic_read_dma_len_o, ic_read_dma_valid_o,
        input  hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/icache_burst.sv
// Direct-mapped instruction cache with burst line refill over DMA.
// Critical (requested) beat is latched during the fill and returned
// one cycle after the last beat; hits return two cycles after acceptance.
module icache_burst #(
    parameter int DW    = 128,
    parameter int AW    = 33,
    parameter int IDX_W = 9,
    parameter int BEATS = 4,
    parameter int OFF_W = 4
) (
    input logic           clk,
    input logic           rst,
    icache_burst_if.slave bus
);
    localparam int BW    = $clog2(BEATS);
    localparam int TAG_W = AW - OFF_W - BW - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_CMP, S_REQ, S_FILL, S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]    addr_q;
    logic [BW-1:0]    beat_cnt_q;
    logic [DW-1:0]    crit_q;
    logic             flush_pend_q;
    logic [31:0]      hit_cnt_q;
    logic [31:0]      miss_cnt_q;
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    logic [DW-1:0]    data_mem [LINES*BEATS];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [DW-1:0]    data_rd_q;
    logic [TAG_W-1:0] tag_rd_q;

    // Fields of the captured request address
    logic [BW-1:0]    req_beat;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    assign req_beat = addr_q[OFF_W+BW-1:OFF_W];
    assign req_idx  = addr_q[OFF_W+BW+IDX_W-1:OFF_W+BW];
    assign req_tag  = addr_q[AW-1:OFF_W+BW+IDX_W];

    logic accept, hit, cmp_hit, cmp_miss, fill_beat, fill_last, to_idle, flush_all;
    assign accept    = (state_q == S_IDLE) && bus.cpu_read_valid_i && !bus.flush_i && !flush_pend_q;
    assign hit       = valid_q[req_idx] && (tag_rd_q == req_tag);
    assign cmp_hit   = (state_q == S_CMP) && hit;
    assign cmp_miss  = (state_q == S_CMP) && !hit;
    assign fill_beat = (state_q == S_FILL) && bus.ic_read_dma_ack_i;
    assign fill_last = fill_beat && (beat_cnt_q == BW'(BEATS - 1));
    assign to_idle   = cmp_hit || (state_q == S_RESP);
    // Immediate flush in IDLE, or deferred flush applied as the response completes
    assign flush_all = ((state_q == S_IDLE) && bus.flush_i) ||
                       (to_idle && (flush_pend_q || bus.flush_i));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_CMP;
            S_CMP:    state_d = hit ? S_IDLE : S_REQ;
            S_REQ:    if (bus.ic_read_dma_ready_i) state_d = S_FILL;
            S_FILL:   if (fill_last) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: response strobe/data and DMA request, zero when inactive
    always_comb begin
        bus.cpu_read_ack_o      = 1'b0;
        bus.ic_data_o           = '0;
        bus.ic_addr_o           = '0;
        bus.ic_read_dma_valid_o = 1'b0;
        bus.ic_read_dma_addr_o  = '0;
        bus.ic_read_dma_len_o   = '0;
        case (state_q)
            S_CMP: begin
                if (hit) begin
                    bus.cpu_read_ack_o = 1'b1;
                    bus.ic_data_o      = data_rd_q;
                    bus.ic_addr_o      = addr_q;
                end
            end
            S_REQ: begin
                bus.ic_read_dma_valid_o = 1'b1;
                bus.ic_read_dma_addr_o  = {addr_q[AW-1:OFF_W+BW], {(OFF_W+BW){1'b0}}};
                bus.ic_read_dma_len_o   = 8'(BEATS - 1);
            end
            S_RESP: begin
                bus.cpu_read_ack_o = 1'b1;
                bus.ic_data_o      = crit_q;
                bus.ic_addr_o      = addr_q;
            end
            default: ;
        endcase
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;

    // Request capture, refill beat counter, critical-beat latch, deferred flush
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            beat_cnt_q   <= '0;
            crit_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (accept) addr_q <= bus.cpu_addr_i;
            if ((state_q == S_REQ) && bus.ic_read_dma_ready_i) beat_cnt_q <= '0;
            else if (fill_beat)                                 beat_cnt_q <= beat_cnt_q + BW'(1);
            if (fill_beat && (beat_cnt_q == req_beat)) crit_q <= bus.ic_read_dma_data_i;
            if (flush_all)                                  flush_pend_q <= 1'b0;
            else if (bus.flush_i && (state_q != S_IDLE))    flush_pend_q <= 1'b1;
        end
    end

    // Saturating hit/miss statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cmp_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (cmp_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    // Per-line valid bit: a miss invalidates, the final beat validates
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        logic sel;
        assign sel         = (req_idx == IDX_W'(gi));
        assign valid_d[gi] = flush_all         ? 1'b0 :
                             (sel && cmp_miss)  ? 1'b0 :
                             (sel && fill_last) ? 1'b1 : valid_q[gi];
    end

    // Valid vector register
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Data array: refill write, registered read of the requested beat
    always_ff @(posedge clk) begin
        if (fill_beat) data_mem[{req_idx, beat_cnt_q}] <= bus.ic_read_dma_data_i;
        data_rd_q <= data_mem[{req_idx, req_beat}];
    end

    // Tag array: written with the final beat, registered read
    always_ff @(posedge clk) begin
        if (fill_last) tag_mem[req_idx] <= req_tag;
        tag_rd_q <= tag_mem[req_idx];
    end
endmodule

// File: doc/icache_burst.md
ICACHE_BURST -- requirements
Module: icache_burst

Interface
REQ-001 The block SHALL have parameter DW, default 128, instruction word / DMA beat width in bits.
REQ-002 The block SHALL have parameter AW, default 33, byte address width.
REQ-003 The block SHALL have parameter IDX_W, default 9, line index width (2^IDX_W lines).
REQ-004 The block SHALL have parameter BEATS, default 4, DW-wide beats per line, a power of 2 and at least 2 (BW = log2(BEATS)).
REQ-005 The block SHALL have parameter OFF_W, default 4, byte-offset bits within a beat (log2(DW/8)).
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-008 The block SHALL have port cpu_addr_i, input, AW bits, CPU fetch byte address.
REQ-009 The block SHALL have port cpu_read_valid_i, input, 1 bit, fetch request, held until ack.
REQ-010 The block SHALL have port ic_data_o, output, DW bits, returned instruction word.
REQ-011 The block SHALL have port ic_addr_o, output, AW bits, address of the returned word.
REQ-012 The block SHALL have port cpu_read_ack_o, output, 1 bit, one-cycle response strobe.
REQ-013 The block SHALL have port flush_i, input, 1 bit, invalidate-all pulse.
REQ-014 The block SHALL have port ic_read_dma_addr_o, output, AW bits, line-aligned refill address.
REQ-015 The block SHALL have port ic_read_dma_len_o, output, 8 bits, burst length minus one (BEATS-1).
REQ-016 The block SHALL have port ic_read_dma_valid_o, output, 1 bit, refill request.
REQ-017 The block SHALL have port ic_read_dma_ready_i, input, 1 bit, DMA accepts the request.
REQ-018 The block SHALL have port ic_read_dma_ack_i, input, 1 bit, per-beat data strobe, beats in ascending order.
REQ-019 The block SHALL have port ic_read_dma_data_i, input, DW bits, refill beat data.
REQ-020 The block SHALL have ports hit_cnt_o and miss_cnt_o, outputs, 32 bits each, saturating hit and miss counters.

Function
REQ-021 The address SHALL decode as: bits [OFF_W-1:0] ignored; beat = [OFF_W+BW-1:OFF_W]; index = next IDX_W bits; tag = the remaining upper bits.
REQ-022 Storage SHALL be direct-mapped with a data array (2^IDX_W*BEATS x DW), a tag array, and a valid-bit register vector; all array reads SHALL be registered (1 cycle).
REQ-023 The FSM states SHALL be IDLE, LOOKUP, CMP, REQ, FILL, RESP.
REQ-024 IDLE->LOOKUP SHALL occur when cpu_read_valid_i=1 and no flush is pending; the address is captured in this transition.
REQ-025 LOOKUP SHALL read the arrays; CMP SHALL determine hit = valid[index] AND tag match.
REQ-026 On a hit in CMP, the block SHALL assert cpu_read_ack_o for 1 cycle with ic_data_o/ic_addr_o valid and increment hit_cnt_o, then return to IDLE; ack SHALL come 2 cycles after acceptance.
REQ-027 On a miss in CMP, the block SHALL clear valid[index], increment miss_cnt_o, and go to REQ.
REQ-028 REQ SHALL hold ic_read_dma_valid_o=1 with addr = captured address with the low OFF_W+BW bits zeroed and len = BEATS-1 until ic_read_dma_ready_i=1, then go to FILL.
REQ-029 In FILL, each ic_read_dma_ack_i SHALL write the beat to {index, beat_cnt}, increment beat_cnt, and latch the beat whose beat_cnt equals the requested beat.
REQ-030 On the final beat, the block SHALL write the tag, set valid[index], and go to RESP.
REQ-031 RESP SHALL ack for 1 cycle with the latched critical beat, then return to IDLE (miss ack 1 cycle after the last beat).
REQ-032 Beats arriving outside FILL SHALL be ignored.
REQ-033 Both counters SHALL saturate at 0xFFFF_FFFF.
REQ-034 flush_i in IDLE SHALL clear all valid bits in the next cycle; a simultaneous cpu_read_valid_i SHALL NOT be accepted that cycle.
REQ-035 flush_i in any other state SHALL set a pending flag, applied on return to IDLE after the response completes; the in-flight response SHALL still be delivered.
REQ-036 A request that hits a line refilled in the immediately preceding RESP SHALL return the new data (no stale read).

Reset
REQ-037 When rst=1 at a clock edge, the block SHALL enter IDLE and clear all valid bits, the pending flush, beat_cnt, both counters, all DMA outputs, cpu_read_ack_o, ic_data_o and ic_addr_o to 0; array contents are don't-care.
REQ-038 Reset mid-FILL SHALL abandon the refill, leave the line invalid, and ignore subsequent beats.

Verification (defaults)
REQ-039 After reset, fetch 0x050 -> dma_addr 0x040, len 3; beats D0..D3 -> ack with ic_data_o=D1, ic_addr_o=0x050; miss_cnt=1.
REQ-040 Then fetch 0x070 -> ack 2 cycles after acceptance, data D3, no DMA request; hit_cnt=1.
REQ-041 Then fetch 0x8050 (same index 1, new tag) -> miss, dma_addr 0x8040; afterwards 0x050 misses again; miss_cnt=3.
REQ-042 flush_i during FILL -> current ack delivered; next fetch of the same line misses.
REQ-043 rst after 2 of 4 beats -> dma_valid=0, counters 0; refetch of the address issues a fresh DMA request; stray acks are ignored.
